// File: rtl/risc_disp_pkg.sv
// Shared definitions for the register display scanner: scan FSM states,
// display geometry and active-low 7-segment glyphs ({g,f,e,d,c,b,a}).
package risc_disp_pkg;

   typedef enum logic [1:0] {
      SELECT  = 2'd0,
      SETTLE  = 2'd1,
      CAPTURE = 2'd2,
      DWELL   = 2'd3
   } scan_state_t;

   localparam int         NUM_DIGITS = 8;
   localparam logic [6:0] SEG_BLANK  = 7'h7F;

   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_B = 7'b0000011;
   localparam logic [6:0] SEG_C = 7'b1000110;
   localparam logic [6:0] SEG_D = 7'b0100001;
   localparam logic [6:0] SEG_E = 7'b0000110;
   localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment glyph decoder.
module hex_to_seg
   import risc_disp_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   // Look up the glyph for the nibble; blank is only a safe default.
   always_comb begin
      seg = SEG_BLANK;
      case (nibble)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/reg_display_scanner.sv
// Readout stage behind the RISC core: selects a register index, waits one
// cycle for the register file read to settle, captures the value, and holds
// it on screen for a dwell period. A free-running refresh multiplexes the
// captured word onto an 8-digit active-low 7-segment display.
module reg_display_scanner
   import risc_disp_pkg::*;
#(
   parameter int NUM_REGS       = 32,
   parameter int DWELL_CYCLES   = 50000000,
   parameter int REFRESH_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        auto_scan,
   input  logic [4:0]  manual_index,
   input  logic        hold,
   input  logic [31:0] Register_return,
   output logic [4:0]  show_index,
   output logic [31:0] disp_value,
   output logic [4:0]  disp_index,
   output logic        capture_valid,
   output logic [7:0]  an,
   output logic [6:0]  seg
);

   localparam int DW_W  = (DWELL_CYCLES > 1)   ? $clog2(DWELL_CYCLES)   : 1;
   localparam int RF_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam int DIG_W = $clog2(NUM_DIGITS);

   localparam logic [DW_W-1:0] DWELL_LAST   = DW_W'(DWELL_CYCLES - 1);
   localparam logic [RF_W-1:0] REFRESH_LAST = RF_W'(REFRESH_CYCLES - 1);
   localparam logic [4:0]      LAST_IDX     = 5'(NUM_REGS - 1);
   localparam logic [5:0]      NUM_REGS_EXT = 6'(NUM_REGS);

   scan_state_t      state;
   logic [DW_W-1:0]  dwell_cnt;
   logic [RF_W-1:0]  refresh_cnt;
   logic [DIG_W-1:0] digit_sel;

   logic [4:0]       manual_clamped;
   logic [4:0]       next_auto;
   logic             dwell_done;
   logic             manual_jump;
   logic [3:0]       nibble;
   logic [6:0]       seg_next;

   // Next-index candidates and dwell exit conditions.
   always_comb begin
      manual_clamped = ({1'b0, manual_index} >= NUM_REGS_EXT) ? LAST_IDX : manual_index;
      next_auto      = (show_index == LAST_IDX) ? 5'd0 : show_index + 5'd1;
      dwell_done     = (dwell_cnt == DWELL_LAST);
      manual_jump    = !auto_scan && (manual_clamped != show_index);
      nibble         = disp_value[{digit_sel, 2'b00} +: 4];
   end

   hex_to_seg u_hex_to_seg (
      .nibble (nibble),
      .seg    (seg_next)
   );

   // Scan FSM: select -> settle -> capture -> dwell, with manual abort and hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= SELECT;
         show_index    <= 5'd0;
         dwell_cnt     <= '0;
         disp_value    <= 32'd0;
         disp_index    <= 5'd0;
         capture_valid <= 1'b0;
      end else begin
         capture_valid <= (state == CAPTURE);
         case (state)
            SELECT:  state <= SETTLE;
            SETTLE:  state <= CAPTURE;
            CAPTURE: begin
               state      <= DWELL;
               disp_value <= Register_return;
               disp_index <= show_index;
               dwell_cnt  <= '0;
            end
            DWELL: begin
               // hold freezes everything, including a pending manual jump
               if (!hold) begin
                  if (manual_jump) begin
                     state      <= SELECT;
                     show_index <= manual_clamped;
                     dwell_cnt  <= '0;
                  end else if (dwell_done) begin
                     state      <= SELECT;
                     show_index <= auto_scan ? next_auto : manual_clamped;
                     dwell_cnt  <= '0;
                  end else begin
                     dwell_cnt <= dwell_cnt + DW_W'(1);
                  end
               end
            end
            default: state <= SELECT;
         endcase
      end
   end

   // Display refresh: step the lit digit and register anode/segment drive.
   always_ff @(posedge clk) begin
      if (rst) begin
         refresh_cnt <= '0;
         digit_sel   <= '0;
         an          <= 8'hFF;
         seg         <= SEG_BLANK;
      end else begin
         an  <= ~(8'd1 << digit_sel);
         seg <= seg_next;
         if (refresh_cnt == REFRESH_LAST) begin
            refresh_cnt <= '0;
            digit_sel   <= digit_sel + DIG_W'(1);
         end else begin
            refresh_cnt <= refresh_cnt + RF_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_reg_display_scanner.sv
// Directed bench for reg_display_scanner with a stub core that returns
// 32'h1000_0000 + show_index (or a fixed display pattern when overridden).
module tb_reg_display_scanner;

   logic        clk = 1'b0;
   logic        rst;
   logic        auto_scan;
   logic [4:0]  manual_index;
   logic        hold;
   logic        override;
   logic [31:0] Register_return;
   logic [4:0]  show_index;
   logic [31:0] disp_value;
   logic [4:0]  disp_index;
   logic        capture_valid;
   logic [7:0]  an;
   logic [6:0]  seg;

   int tests = 0;
   int fails = 0;

   // Expected glyphs for 32'h89AB_CDEF, digit 0 first.
   logic [6:0] exp_seg [8] = '{7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
                               7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000};

   always #5 clk = ~clk;

   assign Register_return = override ? 32'h89AB_CDEF : (32'h1000_0000 + {27'd0, show_index});

   reg_display_scanner #(
      .NUM_REGS       (32),
      .DWELL_CYCLES   (4),
      .REFRESH_CYCLES (2)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .auto_scan       (auto_scan),
      .manual_index    (manual_index),
      .hold            (hold),
      .Register_return (Register_return),
      .show_index      (show_index),
      .disp_value      (disp_value),
      .disp_index      (disp_index),
      .capture_valid   (capture_valid),
      .an              (an),
      .seg             (seg)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance until a capture pulse (bounded), then check gap, index and value.
   task automatic wait_cap(input logic [4:0] idx, input int gap, input logic [31:0] val);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (capture_valid !== 1'b1 && n < 40);
      chk("cap_seen", {31'd0, capture_valid}, 32'd1);
      chk("cap_gap", n, gap);
      chk("cap_index", {27'd0, disp_index}, {27'd0, idx});
      chk("cap_value", disp_value, val);
   endtask

   initial begin
      logic [7:0] prev_an;
      bit         found;

      rst          = 1'b1;
      auto_scan    = 1'b1;
      manual_index = 5'd0;
      hold         = 1'b0;
      override     = 1'b0;

      // Reset state
      repeat (3) tick();
      chk("rst_show_index", {27'd0, show_index}, 32'd0);
      chk("rst_disp_value", disp_value, 32'd0);
      chk("rst_disp_index", {27'd0, disp_index}, 32'd0);
      chk("rst_capture_valid", {31'd0, capture_valid}, 32'd0);
      chk("rst_an", {24'd0, an}, 32'hFF);
      chk("rst_seg", {25'd0, seg}, 32'h7F);

      // Auto scan: first capture three edges after reset release
      rst = 1'b0;
      wait_cap(5'd0, 3, 32'h1000_0000);
      tick();
      chk("pulse_one_cycle", {31'd0, capture_valid}, 32'd0);
      // Remaining captures every 7 cycles; the 7-cycle gap is counted from
      // the sample one cycle after the pulse, so the first uses 6.
      wait_cap(5'd1, 6, 32'h1000_0001);
      for (int i = 2; i <= 32; i++) begin
         wait_cap(5'(i % 32), 7, 32'h1000_0000 + 32'(i % 32));
      end

      // Manual jump to 5 aborts the dwell on the next edge
      auto_scan    = 1'b0;
      manual_index = 5'd5;
      tick();
      chk("manual5_show", {27'd0, show_index}, 32'd5);
      wait_cap(5'd5, 3, 32'h1000_0005);

      // Manual change mid-dwell to 12
      tick();
      manual_index = 5'd12;
      tick();
      chk("manual12_show", {27'd0, show_index}, 32'd12);
      wait_cap(5'd12, 3, 32'h1000_000C);

      // Hold in dwell at index 7
      manual_index = 5'd7;
      tick();
      chk("manual7_show", {27'd0, show_index}, 32'd7);
      wait_cap(5'd7, 3, 32'h1000_0007);
      tick();
      hold = 1'b1;
      for (int i = 0; i < 50; i++) begin
         manual_index = 5'(i * 5 + 1);
         tick();
         chk("hold_show", {27'd0, show_index}, 32'd7);
         chk("hold_value", disp_value, 32'h1000_0007);
         chk("hold_pulse", {31'd0, capture_valid}, 32'd0);
      end
      // Released with dwell count frozen at 1: 3 more dwell edges + 3 to capture
      manual_index = 5'd7;
      hold         = 1'b0;
      wait_cap(5'd7, 6, 32'h1000_0007);

      // Display: capture a known pattern, then freeze it with hold
      override = 1'b1;
      wait_cap(5'd7, 7, 32'h89AB_CDEF);
      hold = 1'b1;
      prev_an = an;
      found   = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick();
         if (an == 8'hFE && prev_an != 8'hFE) found = 1'b1;
         prev_an = an;
      end
      chk("an_fe_found", {31'd0, found}, 32'd1);
      for (int d = 0; d < 8; d++) begin
         chk("an_first", {24'd0, an}, {24'd0, ~(8'd1 << d)});
         chk("seg_digit", {25'd0, seg}, {25'd0, exp_seg[d]});
         tick();
         chk("an_second", {24'd0, an}, {24'd0, ~(8'd1 << d)});
         tick();
      end

      // Reset mid-dwell at index 9
      hold         = 1'b0;
      override     = 1'b0;
      manual_index = 5'd9;
      tick();
      chk("manual9_show", {27'd0, show_index}, 32'd9);
      wait_cap(5'd9, 3, 32'h1000_0009);
      tick();
      rst = 1'b1;
      tick();
      chk("mid_rst_show", {27'd0, show_index}, 32'd0);
      chk("mid_rst_value", disp_value, 32'd0);
      chk("mid_rst_an", {24'd0, an}, 32'hFF);
      chk("mid_rst_seg", {25'd0, seg}, 32'h7F);
      chk("mid_rst_pulse", {31'd0, capture_valid}, 32'd0);
      rst       = 1'b0;
      auto_scan = 1'b1;
      wait_cap(5'd0, 3, 32'h1000_0000);
      wait_cap(5'd1, 7, 32'h1000_0001);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
